prog_sequencer: RTL and testbench

PROG_SEQUENCER -- requirements
Module: prog_sequencer

---
 rtl/prog_sequencer.sv | 81 ++++++++
 tb/tb_prog_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// prog_sequencer: fetches instructions from a synchronous program memory and issues them one at a time
// to a 9-bit processor, waiting for Done with a bounded timeout.
module prog_sequencer #(
  parameter int ADDR_W   = 5,
  parameter int PROG_LEN = 32,
  parameter int LOOP     = 0,
  parameter int TIMEOUT  = 15
)(
  input  logic              clock,
  input  logic              aResetn,
  input  logic              Start,
  input  logic              Stop,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic [8:0]        MemData,
  output logic [8:0]        DataIn,
  output logic              Run,
  input  logic              Done,
  output logic              Busy,
  output logic              Error
);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, ISSUE, WAIT, ERROR, HALT} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PROG_LEN - 1);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  state_t state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [7:0] cnt, cnt_n;
  logic stop_req, stop_req_n;
  always_ff @(posedge clock or negedge aResetn)
    if (!aResetn) begin
      state    <= IDLE;
      pc       <= '0;
      cnt      <= '0;
      stop_req <= 1'b0;
      DataIn   <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      cnt      <= cnt_n;
      stop_req <= stop_req_n;
      if (state == LOAD) DataIn <= MemData;
    end
  // cnt holds the number of WAIT cycles already elapsed without Done
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    cnt_n      = cnt;
    stop_req_n = stop_req;
    case (state)
      IDLE, HALT, ERROR:
        if (Start) begin
          state_n    = FETCH;
          pc_n       = '0;
          stop_req_n = 1'b0;
        end
      FETCH: state_n = LOAD;
      LOAD:  state_n = ISSUE;
      ISSUE: begin
        state_n = WAIT;
        cnt_n   = '0;
      end
      WAIT:
        if (Done) begin
          if (stop_req || Stop) state_n = IDLE;
          else if (pc == LAST) begin
            state_n = (LOOP != 0) ? FETCH : HALT;
            pc_n    = (LOOP != 0) ? '0 : pc;
          end else begin
            state_n = FETCH;
            pc_n    = pc + 1'b1;
          end
        end else if (cnt == TMO_LAST) state_n = ERROR;
        else cnt_n = cnt + 8'd1;
      default: state_n = IDLE;
    endcase
    if (Busy && Stop && !(state == WAIT && Done)) stop_req_n = 1'b1;
  end
  assign MemAddr = pc;
  assign Run     = state == ISSUE;
  assign Busy    = state == FETCH || state == LOAD || state == ISSUE || state == WAIT;
  assign Error   = state == ERROR;
endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: table, directed and random checks of two sequencer configurations (halting and
// wrapping) driven by shared control inputs, each compared against an instruction-level model.
module tb_prog_sequencer;
  logic clock = 1'b0;
  logic aResetn = 1'b0;
  logic Start = 1'b0, Stop = 1'b0, Done = 1'b0;
  logic [4:0] MemAddr_h;
  logic [1:0] MemAddr_w;
  logic [8:0] MemData_h, MemData_w, DataIn_h, DataIn_w;
  logic Run_h, Run_w, Busy_h, Busy_w, Error_h, Error_w;
  logic [8:0] mem [0:31];
  int checks = 0, errors = 0;

  prog_sequencer #(.ADDR_W(5), .PROG_LEN(4), .LOOP(0), .TIMEOUT(15)) dut_h (
    .clock(clock), .aResetn(aResetn), .Start(Start), .Stop(Stop), .MemAddr(MemAddr_h),
    .MemData(MemData_h), .DataIn(DataIn_h), .Run(Run_h), .Done(Done), .Busy(Busy_h), .Error(Error_h));
  prog_sequencer #(.ADDR_W(2), .PROG_LEN(4), .LOOP(1), .TIMEOUT(5)) dut_w (
    .clock(clock), .aResetn(aResetn), .Start(Start), .Stop(Stop), .MemAddr(MemAddr_w),
    .MemData(MemData_w), .DataIn(DataIn_w), .Run(Run_w), .Done(Done), .Busy(Busy_w), .Error(Error_w));

  always #5 clock = ~clock;
  always @(posedge clock) begin
    MemData_h <= mem[MemAddr_h];
    MemData_w <= mem[{3'b0, MemAddr_w}];
  end

  // mode: 0 idle, 1 running, 2 halted, 3 error; pos: 0 fetch, 1 load, 2 issue, 3 waiting
  typedef struct { int mode; int pos; int pc; int waited; bit sreq; logic [8:0] din; } mdl_t;
  mdl_t mh, mw;
  localparam mdl_t MRST = '{0, 0, 0, 0, 1'b0, 9'd0};

  function automatic mdl_t step(mdl_t m, bit st, bit sp, bit dn, int len, bit loop, int tmo);
    mdl_t n = m;
    if (m.mode != 1) begin
      if (st) begin
        n.mode = 1; n.pos = 0; n.pc = 0; n.sreq = 1'b0;
      end
      return n;
    end
    if (sp) n.sreq = 1'b1;
    if (m.pos == 0) n.pos = 1;
    else if (m.pos == 1) begin
      n.din = mem[m.pc]; n.pos = 2;
    end else if (m.pos == 2) begin
      n.pos = 3; n.waited = 0;
    end else if (dn) begin
      n.pos = 0;
      if (m.sreq || sp) n.mode = 0;
      else if (m.pc == len - 1) begin
        if (loop) n.pc = 0;
        else n.mode = 2;
      end else n.pc = m.pc + 1;
    end else if (m.waited + 1 == tmo) n.mode = 3;
    else n.waited = m.waited + 1;
    return n;
  endfunction

  function automatic logic [31:0] expv(mdl_t m);
    return (32'(m.pc) << 12) | (32'(m.din) << 3) | (32'(m.mode == 1 && m.pos == 2) << 2)
         | (32'(m.mode == 1) << 1) | 32'(m.mode == 3);
  endfunction
  function automatic logic [31:0] got_h();
    return 32'({MemAddr_h, DataIn_h, Run_h, Busy_h, Error_h});
  endfunction
  function automatic logic [31:0] got_w();
    return 32'({MemAddr_w, DataIn_w, Run_w, Busy_w, Error_w});
  endfunction

  task automatic cmp(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic cycle(bit st, bit sp, bit dn);
    Start = st; Stop = sp; Done = dn;
    @(posedge clock);
    if (aResetn) begin
      mh = step(mh, st, sp, dn, 4, 1'b0, 15);
      mw = step(mw, st, sp, dn, 4, 1'b1, 5);
    end
    @(negedge clock);
    cmp("model_h", got_h(), expv(mh));
    cmp("model_w", got_w(), expv(mw));
  endtask

  task automatic do_reset();
    Start = 0; Stop = 0; Done = 0; aResetn = 0;
    mh = MRST; mw = MRST;
    repeat (2) @(negedge clock);
    aResetn = 1;
    cmp("reset_h", got_h(), 32'd0);
    cmp("reset_w", got_w(), 32'd0);
  endtask

  typedef struct { bit st; bit sp; bit dn; logic [4:0] addr; logic [8:0] din; bit run; bit busy; bit err; } vec_t;
  function automatic vec_t mk(bit st, bit sp, bit dn, int addr, logic [8:0] din, bit run, bit busy, bit err);
    vec_t v;
    v.st = st; v.sp = sp; v.dn = dn; v.addr = 5'(addr); v.din = din; v.run = run; v.busy = busy; v.err = err;
    return v;
  endfunction

  vec_t vt [22];
  int dprob;

  initial begin
    mem[0] = 9'h0A5; mem[1] = 9'h1C3; mem[2] = 9'h05A; mem[3] = 9'h1FF;
    for (int i = 4; i < 32; i++) mem[i] = 9'($urandom);
    for (int k = 0; k < 4; k++) begin
      vt[5*k]   = mk(k == 0, 0, k > 0, k, k > 0 ? mem[k-1] : 9'd0, 0, 1, 0);
      vt[5*k+1] = mk(0, 0, 0, k, k > 0 ? mem[k-1] : 9'd0, 0, 1, 0);
      vt[5*k+2] = mk(0, 0, 0, k, mem[k], 1, 1, 0);
      vt[5*k+3] = mk(0, 0, 0, k, mem[k], 0, 1, 0);
      vt[5*k+4] = mk(0, 0, 0, k, mem[k], 0, 1, 0);
    end
    vt[20] = mk(0, 0, 1, 3, mem[3], 0, 0, 0);
    vt[21] = mk(0, 1, 1, 3, mem[3], 0, 0, 0);

    do_reset();
    repeat (3) cycle(0, 1, 1);
    cmp("idle_hold", got_h(), 32'd0);
    for (int i = 0; i < 22; i++) begin
      cycle(vt[i].st, vt[i].sp, vt[i].dn);
      cmp($sformatf("vec%0d", i), got_h(),
          32'({vt[i].addr, vt[i].din, vt[i].run, vt[i].busy, vt[i].err}));
      if (i == 20) cmp("wrap_addr", 32'({MemAddr_w, Busy_w}), 32'(3'b001));
    end
    cycle(0, 0, 0);
    cmp("wrap_run", 32'(Run_w), 32'd1);

    // stop requested during the issue of address 1
    do_reset();
    cycle(1, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0);
    cycle(0, 0, 1); cycle(0, 0, 0);
    cycle(0, 0, 0);
    cmp("stop_issue", 32'({MemAddr_h, Run_h}), 32'({5'd1, 1'b1}));
    cycle(0, 1, 0); cycle(0, 0, 0); cycle(0, 0, 1);
    cmp("stop_idle", got_h(), 32'({5'd1, mem[1], 3'b000}));
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1);
      cmp("stop_norun", 32'({Run_h, Busy_h}), 32'd0);
    end

    // timeout: Done in the 15th wait cycle is accepted, silence for 15 cycles errors
    do_reset();
    cycle(1, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0);
    repeat (14) cycle(0, 0, 0);
    cmp("wait15", 32'({Busy_h, Error_h}), 32'(2'b10));
    cycle(0, 0, 1);
    cmp("late_done", 32'({MemAddr_h, Busy_h, Error_h}), 32'({5'd1, 2'b10}));
    cycle(0, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0);
    repeat (14) cycle(0, 0, 0);
    cmp("pre_tmo", 32'(Error_h), 32'd0);
    cycle(0, 0, 0);
    cmp("tmo", 32'({Busy_h, Error_h}), 32'(2'b01));
    cycle(0, 1, 1);
    cmp("err_hold", 32'({Busy_h, Error_h}), 32'(2'b01));
    cycle(1, 0, 0);
    cmp("err_restart", 32'({MemAddr_h, Busy_h, Error_h}), 32'({5'd0, 2'b10}));

    // asynchronous reset in the middle of a wait
    do_reset();
    cycle(1, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0);
    #2 aResetn = 0;
    mh = MRST; mw = MRST;
    #1 cmp("async_h", got_h(), 32'd0);
    cmp("async_w", got_w(), 32'd0);
    @(negedge clock);
    aResetn = 1;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1);
      cmp("post_rst", 32'({Run_h, Busy_h, Run_w, Busy_w}), 32'd0);
    end

    // random stimulus against the models
    do_reset();
    dprob = 4;
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) dprob = $urandom_range(1, 15);
      if ($urandom_range(0, 299) == 0) begin
        #($urandom_range(1, 8)) aResetn = 0;
        mh = MRST; mw = MRST;
        #1 cmp("rnd_rst_h", got_h(), 32'd0);
        cmp("rnd_rst_w", got_w(), 32'd0);
        @(negedge clock);
        aResetn = 1;
      end else
        cycle($urandom_range(0, 24) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 15) < dprob);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
